// File: rtl/microsequencer_if.sv
// Sequencer-side signal bundle: instruction/ROM/datapath inputs and sequencing outputs.
interface microsequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic                run;
    logic [7:0]          opcode;
    logic [15:0]         uinstr;
    logic [PC_WIDTH-1:0] bus;
    logic                alu_c;
    logic [10:0]         uaddr;
    logic [2:0]          tstate;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          flags;
    logic                instr_done;

    modport master (
        output run, opcode, uinstr, bus, alu_c,
        input  uaddr, tstate, pc, flags, instr_done
    );

    modport slave (
        input  run, opcode, uinstr, bus, alu_c,
        output uaddr, tstate, pc, flags, instr_done
    );
endinterface

// File: rtl/microsequencer.sv
// SCAMP microsequencer: T-state counter, microcode ROM addressing, program counter,
// ALU flag latch and conditional jump resolution.
module microsequencer #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             reset_bar,
    microsequencer_if.slave sif
);
    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, T7
    } tstate_e;

    tstate_e             tstate;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          flags;
    logic                eo;
    logic                rt;
    logic                pp;
    logic                take;

    // Flag word {C, Z, GT, LT} produced by an ALU bus drive.
    function automatic logic [3:0] next_flags(input logic carry, input logic [PC_WIDTH-1:0] value);
        logic zero;
        zero = (value == '0);
        return {carry, zero, ~zero & ~value[PC_WIDTH-1], value[PC_WIDTH-1]};
    endfunction

    assign eo   = ~sif.uinstr[15];
    assign rt   = sif.uinstr[15] & sif.uinstr[11];
    assign pp   = sif.uinstr[15] & sif.uinstr[10];
    // Jumps test the flags held before this edge, even when the same word drives EO.
    assign take = |(sif.uinstr[5:2] & flags);

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            tstate <= T0;
            pc     <= RESET_PC;
            flags  <= 4'b0000;
        end else if (sif.run) begin
            tstate <= rt ? T0 : tstate_e'(tstate + 3'd1);
            if (eo) begin
                flags <= next_flags(sif.alu_c, sif.bus);
            end
            if (take) begin
                pc <= sif.bus;
            end else if (pp) begin
                pc <= pc + PC_WIDTH'(1);
            end
        end
    end

    // Address depends only on registered tstate and opcode, so there is no loop through the ROM.
    assign sif.uaddr      = {sif.opcode, tstate};
    assign sif.tstate     = tstate;
    assign sif.pc         = pc;
    assign sif.flags      = flags;
    assign sif.instr_done = reset_bar & sif.run & (rt | (tstate == T7));
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer with a reference model feeding an expected-state scoreboard.
module tb_microsequencer;
    localparam int          PC_WIDTH = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct {
        string       tag;
        logic [2:0]  t;
        logic [15:0] pc;
        logic [3:0]  fl;
    } exp_t;

    logic clk;
    logic reset_bar;
    int   errors;
    int   checks;
    exp_t sb[$];

    logic [2:0]  m_t;
    logic [15:0] m_pc;
    logic [3:0]  m_fl;

    microsequencer_if #(.PC_WIDTH(PC_WIDTH)) sif ();

    microsequencer #(
        .PC_WIDTH(PC_WIDTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk      (clk),
        .reset_bar(reset_bar),
        .sif      (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one microinstruction (called after an edge), push the expected post-edge state,
    // check combinational outputs mid-cycle, then pop and compare after the edge.
    task automatic step(input string tag, input logic r, input logic [15:0] u,
                        input logic [15:0] b, input logic c);
        exp_t e;
        exp_t got;
        logic eo, rt, pp, take, z, exp_done;
        sif.run    = r;
        sif.uinstr = u;
        sif.bus    = b;
        sif.alu_c  = c;
        eo   = !u[15];
        rt   = u[15] & u[11];
        pp   = u[15] & u[10];
        take = |(u[5:2] & m_fl);
        exp_done = r & (rt | (m_t == 3'd7));
        e.tag = tag;
        e.t   = m_t;
        e.pc  = m_pc;
        e.fl  = m_fl;
        if (r) begin
            e.t = rt ? 3'd0 : m_t + 3'd1;
            if (eo) begin
                z    = (b == 16'h0000);
                e.fl = {c, z, !z & !b[15], b[15]};
            end
            if (take) e.pc = b;
            else if (pp) e.pc = m_pc + 16'd1;
        end
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_uaddr"}, 32'(sif.uaddr), 32'({sif.opcode, m_t}));
        chk({tag, "_done"}, 32'(sif.instr_done), 32'(exp_done));
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, "_tstate"}, 32'(sif.tstate), 32'(got.t));
        chk({got.tag, "_pc"}, 32'(sif.pc), 32'(got.pc));
        chk({got.tag, "_flags"}, 32'(sif.flags), 32'(got.fl));
        m_t  = got.t;
        m_pc = got.pc;
        m_fl = got.fl;
    endtask

    initial begin
        logic [2:0]  hold_t;
        logic [15:0] hold_pc;
        logic [3:0]  hold_fl;
        errors = 0;
        checks = 0;
        reset_bar  = 1'b0;
        sif.run    = 1'b1;
        sif.opcode = 8'h12;
        sif.uinstr = 16'h8800;
        sif.bus    = 16'h0000;
        sif.alu_c  = 1'b0;

        #2;
        chk("rst_tstate", 32'(sif.tstate), 32'd0);
        chk("rst_pc", 32'(sif.pc), 32'(RESET_PC));
        chk("rst_flags", 32'(sif.flags), 32'd0);
        chk("rst_uaddr", 32'(sif.uaddr), 32'h090);
        chk("rst_done", 32'(sif.instr_done), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_tstate", 32'(sif.tstate), 32'd0);
        reset_bar = 1'b1;
        m_t  = 3'd0;
        m_pc = RESET_PC;
        m_fl = 4'b0000;

        // Free run: uaddr walks 0x090..0x097 and wraps.
        for (int i = 0; i < 9; i++) begin
            chk("free_uaddr_const", 32'(sif.uaddr), 32'h090 + 32'(i % 8));
            step("free", 1'b1, 16'h0000, 16'h0000, 1'b0);
        end
        step("free", 1'b1, 16'h0000, 16'h0000, 1'b0);
        chk("pre_rt_tstate", 32'(sif.tstate), 32'd2);

        step("rt", 1'b1, 16'h8800, 16'h0000, 1'b0);
        chk("rt_tstate0", 32'(sif.tstate), 32'd0);
        chk("rt_pc_same", 32'(sif.pc), 32'h0000);

        // Z is set from the free run; force pc to FFFF, then increment across the wrap.
        step("jz_ffff", 1'b1, 16'h8010, 16'hFFFF, 1'b0);
        chk("jz_ffff_pc", 32'(sif.pc), 32'hFFFF);
        step("pp_wrap", 1'b1, 16'h8400, 16'h1111, 1'b0);
        chk("pp_wrap_pc", 32'(sif.pc), 32'h0000);

        step("eo_a", 1'b1, 16'h0000, 16'h0000, 1'b1);
        chk("eo_a_flags", 32'(sif.flags), 32'b1100);
        step("jz", 1'b1, 16'h8010, 16'h1234, 1'b0);
        chk("jz_pc", 32'(sif.pc), 32'h1234);
        step("jgt", 1'b1, 16'h8008, 16'h5555, 1'b0);
        chk("jgt_pc", 32'(sif.pc), 32'h1234);

        step("jz_pp", 1'b1, 16'h8410, 16'h0400, 1'b0);
        chk("jz_pp_pc", 32'(sif.pc), 32'h0400);

        // EO plus JZ: the jump sees the old Z=1 while new flags become GT.
        step("eo_jz", 1'b1, 16'h0010, 16'h0777, 1'b0);
        chk("eo_jz_pc", 32'(sif.pc), 32'h0777);
        chk("eo_jz_flags", 32'(sif.flags), 32'b0010);
        step("nomask", 1'b1, 16'h8000, 16'h9999, 1'b0);
        chk("nomask_pc", 32'(sif.pc), 32'h0777);
        step("eo_lt", 1'b1, 16'h0000, 16'h8000, 1'b0);
        chk("eo_lt_flags", 32'(sif.flags), 32'b0001);

        // Stall with an active RT/PP/jump word and a new opcode.
        hold_t  = sif.tstate;
        hold_pc = sif.pc;
        hold_fl = sif.flags;
        sif.opcode = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 16'h8C3C, 16'hABCD, 1'b1);
        end
        chk("stall_tstate", 32'(sif.tstate), 32'(hold_t));
        chk("stall_pc", 32'(sif.pc), 32'(hold_pc));
        chk("stall_flags", 32'(sif.flags), 32'(hold_fl));

        // Reach tstate=5, pc=0042, then reset asynchronously between edges.
        step("jlt_rt", 1'b1, 16'h8804, 16'h0042, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("adv", 1'b1, 16'h8000, 16'h0000, 1'b0);
        end
        chk("pre_arst_tstate", 32'(sif.tstate), 32'd5);
        chk("pre_arst_pc", 32'(sif.pc), 32'h0042);
        #1;
        reset_bar = 1'b0;
        #1;
        chk("arst_tstate", 32'(sif.tstate), 32'd0);
        chk("arst_pc", 32'(sif.pc), 32'(RESET_PC));
        chk("arst_flags", 32'(sif.flags), 32'd0);
        chk("arst_done", 32'(sif.instr_done), 32'd0);
        #1;
        reset_bar = 1'b1;
        m_t  = 3'd0;
        m_pc = RESET_PC;
        m_fl = 4'b0000;
        step("first", 1'b1, 16'h8000, 16'h0000, 1'b0);
        chk("first_tstate", 32'(sif.tstate), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/microsequencer.md
# microsequencer

Sequences the SCAMP microcode: holds the T-state counter, forms the microcode ROM address from the current opcode and T-state, and owns the program counter. It also latches ALU flags and resolves conditional jumps. It sits between the instruction register and the microcode ROM, and its ROM output feeds the microinstruction decoder. It consumes the same 16-bit microinstruction word that the decoder decodes, reading only the bits that affect sequencing.

## Interface
Parameters:
- PC_WIDTH, 16, program counter width; equals bus width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_bar  in  1  asynchronous, active-low reset.
- run  in  1  advance enable; low stalls all state.
- opcode  in  8  instruction register high byte.
- uinstr  in  16  microinstruction currently read from ROM at uaddr.
- bus  in  16  datapath bus value this cycle.
- alu_c  in  1  ALU carry-out this cycle.
- uaddr  out  11  microcode ROM address = {opcode, tstate}, combinational.
- tstate  out  3  current T-state.
- pc  out  PC_WIDTH  program counter.
- flags  out  4  latched {C, Z, GT, LT}.
- instr_done  out  1  high in the last microinstruction of an instruction.

## Operation
Microinstruction fields used (uinstr[15] is EO_bar):
- ALU drives bus ("EO") when uinstr[15]==0.
- RT = uinstr[15] & uinstr[11].
- PP = uinstr[15] & uinstr[10].
- jump mask {JC, JZ, JGT, JLT} = uinstr[5:2]; these bits are valid regardless of uinstr[15].

T-state counter:
- Reset value is 0.
- When run=1 and RT=1: tstate <= 0.
- Else when run=1: tstate <= tstate+1; 7 wraps to 0 with no RT needed.
- instr_done = run & (RT | tstate==7), combinational.

Flag latch:
- Reset value is 4'b0000.
- When run=1 and EO, on the edge:
  - C <= alu_c
  - Z <= (bus==0)
  - LT <= bus[15]
  - GT <= !Z_new & !bus[15]
- Flags are not updated when EO is inactive.

Jump resolution:
- take = |(uinstr[5:2] & {C,Z,GT,LT}), using the registered (pre-edge) flags.
- A jump in the same microinstruction as an EO therefore tests the old flags.
- A mask of 0 never jumps.

PC update (only when run=1):
- If take: pc <= bus.
- Else if PP: pc <= pc+1, modulo 2^PC_WIDTH (FFFF -> 0000).
- If take and PP coincide, take wins and the increment is dropped.
- Reset value is RESET_PC.

Stall and reset:
- run=0: tstate, pc and flags hold, and instr_done=0.
- uaddr still tracks opcode during a stall.
- reset_bar low at any time, including mid-instruction, immediately clears tstate, flags and pc with no clock.
- The first edge after reset_bar rises executes microinstruction {opcode, 0}.

## Timing
- The microcode ROM is asynchronous-read.
  - uaddr depends only on registered tstate and the opcode input.
  - uinstr is valid within the same cycle.
- One microinstruction per clk while run=1.
- All register updates (tstate, pc, flags) take effect at the rising edge ending the microinstruction.
  - New values are visible the following cycle.
- No combinational path from uinstr to uaddr; no loop through the ROM.
- instr_done is combinational from uinstr and tstate, so it is valid late in the cycle.
- Outputs in reset: tstate=0, pc=RESET_PC, flags=0, uaddr={opcode,3'b0}, instr_done=0.

## Test plan
- Reset then free-run, opcode=8'h12, uinstr=16'h0000, run=1:
  - uaddr steps 0x090..0x097 then back to 0x090.
  - instr_done high only at tstate=7.
- RT early: uinstr=16'h8800 at tstate=2.
  - Next cycle tstate=0.
  - instr_done=1 at tstate=2.
  - pc unchanged.
- PP increment and wrap:
  - Force pc=16'hFFFF via jump.
  - Apply uinstr=16'h8400.
  - pc becomes 16'h0000.
- Flags then jump:
  - Cycle A: uinstr[15]=0 with bus=16'h0000 and alu_c=1; flags become C=1, Z=1, GT=0, LT=0.
  - Cycle B: uinstr=16'h8010 (JZ) with bus=16'h1234; pc becomes 16'h1234.
  - Same test with uinstr=16'h8008 (JGT): pc unchanged.
- Jump + PP together: flags Z=1, uinstr=16'h8410, bus=16'h0400 -> pc=16'h0400, not incremented.
- Stall and async reset:
  - run=0 for 3 cycles: tstate, pc and flags frozen; instr_done=0.
  - reset_bar pulsed low mid-cycle at tstate=5, pc=16'h0042: tstate=0 and pc=RESET_PC immediately, with no clock edge.
